// File: rtl/tb_dina_map_pkg.sv
// Shared definitions for the temp-buffer write-side mapper.
// Direction codes match the temp-buffer read mapper so a single dir field from
// the top-level sequencer can drive both sides.
package tb_dina_map_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  // l_k_0 value selecting which half of the TB word a NEW landmark lands in.
  localparam logic DIR_NEW_0 = 1'b0;
  localparam logic DIR_NEW_1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/tb_dina_lane_mux.sv
// Combinational lane mapper: RSA C-output row -> TB write data and lane enables.
// Ports:
//   dir     direction code (IDLE/POS/NEG/NEW)
//   l_k_0   NEW-landmark half select
//   c_dout  RSA row, lane i at [i*RSA_DW +: RSA_DW]
//   dina    TB data lanes; lanes not enabled are forced to 0
//   wea     per-lane write enable
module tb_dina_lane_mux
  import tb_dina_map_pkg::*;
#(
  parameter int X      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 32
) (
  input  logic [1:0]          dir,
  input  logic                l_k_0,
  input  logic [X*RSA_DW-1:0] c_dout,
  output logic [L*RSA_DW-1:0] dina,
  output logic [L-1:0]        wea
);

  localparam int HALF = L / 2;

  always_comb begin
    dina = '0;
    wea  = '0;
    case (dir)
      DIR_POS: begin
        for (int i = 0; i < L; i++) begin
          dina[i*RSA_DW +: RSA_DW] = c_dout[i*RSA_DW +: RSA_DW];
          wea[i]                   = 1'b1;
        end
      end
      DIR_NEG: begin
        for (int i = 0; i < L; i++) begin
          dina[i*RSA_DW +: RSA_DW] = c_dout[(X-1-i)*RSA_DW +: RSA_DW];
          wea[i]                   = 1'b1;
        end
      end
      DIR_NEW: begin
        // Only the first HALF result lanes carry a NEW landmark; they are
        // steered into the low or high half of the TB word.
        for (int i = 0; i < HALF; i++) begin
          case (l_k_0)
            DIR_NEW_1: begin
              dina[i*RSA_DW +: RSA_DW] = c_dout[i*RSA_DW +: RSA_DW];
              wea[i]                   = 1'b1;
            end
            DIR_NEW_0: begin
              dina[(i+HALF)*RSA_DW +: RSA_DW] = c_dout[i*RSA_DW +: RSA_DW];
              wea[i+HALF]                     = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tb_dina_map.sv
// Temp-buffer write mapper: sequences one block of RSA result rows into
// consecutive TB port-A addresses.
// Ports:
//   clk, sys_rst_n      clock, async active-low reset
//   start               one-cycle pulse; latches dir, l_k_0, base_addr, n_rows
//   dir, l_k_0          lane mapping selection
//   base_addr, n_rows   first write address, beats in block (0 = empty)
//   C_dout, C_dout_valid RSA result row and its valid
//   busy, done, ovf     status: in block, end pulse, sticky overflow
//   TB_dina, TB_wea, TB_addra  registered TB write port
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// WRITE | accepting beats until n_rows have been written
// DONE  | block finished; done pulses in the following cycle, then IDLE
module tb_dina_map
  import tb_dina_map_pkg::*;
#(
  parameter int X          = 4,   // must equal L
  parameter int L          = 4,
  parameter int RSA_DW     = 32,
  parameter int TB_AW      = 10,
  parameter int SEQ_CNT_DW = 5
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [1:0]            dir,
  input  logic                  l_k_0,
  input  logic [TB_AW-1:0]      base_addr,
  input  logic [SEQ_CNT_DW-1:0] n_rows,
  input  logic [X*RSA_DW-1:0]   C_dout,
  input  logic                  C_dout_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [L*RSA_DW-1:0]   TB_dina,
  output logic [L-1:0]          TB_wea,
  output logic [TB_AW-1:0]      TB_addra
);

  state_e                state_q, state_d;
  logic [1:0]            dir_q;
  logic                  lk_q;
  logic [SEQ_CNT_DW-1:0] n_q;
  logic [SEQ_CNT_DW-1:0] cnt_q;
  logic [SEQ_CNT_DW-1:0] cnt_inc;
  logic [TB_AW-1:0]      addr_q;

  logic                  busy_q, done_q, ovf_q;
  logic [L*RSA_DW-1:0]   dina_q;
  logic [L-1:0]          wea_q;
  logic [TB_AW-1:0]      addra_q;

  logic                  accept, beat, ovf_set;
  logic [L*RSA_DW-1:0]   mux_dina;
  logic [L-1:0]          mux_wea;

  assign cnt_inc = cnt_q + 1'b1;

  tb_dina_lane_mux #(
    .X      (X),
    .L      (L),
    .RSA_DW (RSA_DW)
  ) u_lane_mux (
    .dir    (dir_q),
    .l_k_0  (lk_q),
    .c_dout (C_dout),
    .dina   (mux_dina),
    .wea    (mux_wea)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    beat    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          // Empty or IDLE-direction blocks complete without writing.
          if ((n_rows == '0) || (dir == DIR_IDLE)) state_d = ST_DONE;
          else                                     state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (C_dout_valid) begin
          beat = 1'b1;
          if (cnt_inc == n_q) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // WRITE with a full count is unreachable since the last beat leaves WRITE;
  // in practice ovf flags surplus beats landing in DONE.
  assign ovf_set = C_dout_valid &&
                   ((state_q == ST_DONE) || ((state_q == ST_WRITE) && (cnt_q == n_q)));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dir_q   <= DIR_IDLE;
      lk_q    <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dina_q  <= '0;
      wea_q   <= '0;
      addra_q <= '0;
    end else begin
      done_q <= (state_q == ST_DONE);

      if (accept) begin
        dir_q  <= dir;
        lk_q   <= l_k_0;
        n_q    <= n_rows;
        cnt_q  <= '0;
        addr_q <= base_addr;
        busy_q <= 1'b1;
      end else if (state_q == ST_DONE) begin
        busy_q <= 1'b0;
      end

      if (accept)       ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;

      if (beat) begin
        dina_q  <= mux_dina;
        wea_q   <= mux_wea;
        addra_q <= addr_q;
        addr_q  <= addr_q + 1'b1;  // wraps modulo 2^TB_AW
        cnt_q   <= cnt_inc;
      end else begin
        dina_q  <= '0;
        wea_q   <= '0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign TB_dina  = dina_q;
  assign TB_wea   = wea_q;
  assign TB_addra = addra_q;

endmodule

// File: tb/tb_tb_dina_map.sv
// Self-checking bench for tb_dina_map: directed blocks followed by random
// blocks, compared against a behavioural model of the write mapping.
module tb_tb_dina_map;

  localparam int X  = 4;
  localparam int L  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      dir = 2'b00;
  logic            l_k_0 = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [CW-1:0]   n_rows = '0;
  logic [X*DW-1:0] C_dout = '0;
  logic            C_dout_valid = 1'b0;
  logic            busy, done, ovf;
  logic [L*DW-1:0] TB_dina;
  logic [L-1:0]    TB_wea;
  logic [AW-1:0]   TB_addra;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  always #5 clk = ~clk;

  tb_dina_map #(
    .X(X), .L(L), .RSA_DW(DW), .TB_AW(AW), .SEQ_CNT_DW(CW)
  ) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .dir          (dir),
    .l_k_0        (l_k_0),
    .base_addr    (base_addr),
    .n_rows       (n_rows),
    .C_dout       (C_dout),
    .C_dout_valid (C_dout_valid),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf),
    .TB_dina      (TB_dina),
    .TB_wea       (TB_wea),
    .TB_addra     (TB_addra)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference mapping: which result lane lands in which TB lane.
  function automatic void model_map(input logic [1:0] d, input logic lk, input logic [127:0] c,
                                    output logic [127:0] dina, output logic [3:0] wea);
    logic [31:0] ln [4];
    for (int i = 0; i < 4; i++) ln[i] = c[i*32 +: 32];
    dina = '0;
    wea  = 4'h0;
    case (d)
      2'b01: begin
        dina = {ln[3], ln[2], ln[1], ln[0]};
        wea  = 4'hF;
      end
      2'b10: begin
        dina = {ln[0], ln[1], ln[2], ln[3]};
        wea  = 4'hF;
      end
      2'b11: begin
        if (lk) begin
          dina = {32'd0, 32'd0, ln[1], ln[0]};
          wea  = 4'b0011;
        end else begin
          dina = {ln[1], ln[0], 32'd0, 32'd0};
          wea  = 4'b1100;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [127:0] scale(input logic [127:0] p, input int k);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = p[i*32 +: 32] * 32'(k);
    return r;
  endfunction

  task automatic step(input logic s, input logic v, input logic [127:0] c);
    start        = s;
    C_dout_valid = v;
    C_dout       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_ovf"},  128'(ovf),  128'(0));
    chk({tag, "_wea"},  128'(TB_wea), 128'(0));
    chk({tag, "_dina"}, 128'(TB_dina), 128'(0));
    chk({tag, "_addr"}, 128'(TB_addra), 128'(0));
  endtask

  // One complete block: start, beats (with gaps), done cycle, settle cycle.
  task automatic run_block(input logic [1:0] d, input logic lk, input logic [AW-1:0] base,
                           input int n, input int gap_pct, input int forced_gap,
                           input bit rnd_data, input logic [127:0] cpat, input bit scale_k,
                           input bit restart, input bit extra);
    int beats, cyc, fg, n_eff;
    logic v;
    logic [127:0] c, edina;
    logic [3:0] ewea;
    logic [AW-1:0] eaddr;
    n_eff     = (d == 2'b00) ? 0 : n;
    dir       = d;
    l_k_0     = lk;
    base_addr = base;
    n_rows    = n[CW-1:0];
    step(1'b1, 1'b0, '0);
    chk("start_busy", 128'(busy), 128'(1));
    chk("start_ovf", 128'(ovf), 128'(0));
    chk("start_wea", 128'(TB_wea), 128'(0));
    beats = 0;
    cyc   = 0;
    fg    = forced_gap;
    while (beats < n_eff && cyc < 300) begin
      if (fg > 0 && beats == 1) begin
        v = 1'b0;
        fg--;
      end else begin
        v = ($urandom_range(0, 99) >= gap_pct);
      end
      c = rnd_data ? {$urandom, $urandom, $urandom, $urandom}
                   : scale(cpat, scale_k ? beats + 1 : 1);
      if (restart && cyc == 0) begin
        dir       = ~d;
        l_k_0     = ~lk;
        base_addr = ~base;
        n_rows    = ~n_rows;
      end
      step(restart && cyc == 0, v, c);
      cyc++;
      if (v) begin
        model_map(d, lk, c, edina, ewea);
        eaddr = base + beats[AW-1:0];
        chk("beat_wea", 128'(TB_wea), 128'(ewea));
        chk("beat_dina", TB_dina, edina);
        chk("beat_addr", 128'(TB_addra), 128'(eaddr));
        last_addr = eaddr;
        beats++;
      end else begin
        chk("gap_wea", 128'(TB_wea), 128'(0));
        chk("gap_dina", TB_dina, '0);
        chk("gap_addr", 128'(TB_addra), 128'(last_addr));
      end
      chk("beat_done", 128'(done), 128'(0));
      chk("beat_busy", 128'(busy), 128'(1));
    end
    if (beats < n_eff) chk("beat_budget", 128'(beats), 128'(n_eff));
    // DONE state: a start or a surplus beat here must be ignored.
    step(restart, extra, {$urandom, $urandom, $urandom, $urandom});
    chk("done_pulse", 128'(done), 128'(1));
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_wea", 128'(TB_wea), 128'(0));
    chk("done_ovf", 128'(ovf), 128'(extra));
    step(1'b0, 1'b0, '0);
    chk("post_done", 128'(done), 128'(0));
    chk("post_busy", 128'(busy), 128'(0));
    chk("post_wea", 128'(TB_wea), 128'(0));
  endtask

  initial begin
    logic [127:0] c;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    sys_rst_n = 1'b1;
    step(1'b0, 1'b0, '0);

    // POS, rows scaled by beat number
    run_block(2'b01, 1'b0, 10'h010, 3, 0, 0, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, 1'b0, 1'b0);
    // NEG with a two-cycle gap after the first beat
    run_block(2'b10, 1'b0, 10'h020, 2, 0, 2, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b0, 1'b0);
    // NEW halves
    run_block(2'b11, 1'b1, 10'h030, 2, 0, 0, 1'b0, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, 1'b0, 1'b0);
    run_block(2'b11, 1'b0, 10'h031, 2, 0, 0, 1'b0, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, 1'b0, 1'b0);
    // address wrap, empty block, IDLE direction
    run_block(2'b01, 1'b0, 10'h3FF, 2, 0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    run_block(2'b01, 1'b0, 10'h100, 0, 0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    run_block(2'b00, 1'b0, 10'h100, 3, 0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    // start while busy / in DONE, then surplus beat in DONE and ovf clear
    run_block(2'b01, 1'b0, 10'h040, 3, 20, 0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    run_block(2'b10, 1'b0, 10'h050, 2, 0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    run_block(2'b01, 1'b0, 10'h060, 1, 0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset after 1 of 3 beats
    dir = 2'b01; l_k_0 = 1'b0; base_addr = 10'h100; n_rows = 5'd3;
    step(1'b1, 1'b0, '0);
    c = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 1'b1, c);
    chk("rst_pre_wea", 128'(TB_wea), 128'(4'hF));
    chk("rst_pre_dina", TB_dina, c);
    chk("rst_pre_addr", 128'(TB_addra), 128'(10'h100));
    C_dout_valid = 1'b1;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    last_addr = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      chk_idle_outputs("rst_after");
    end
    run_block(2'b01, 1'b0, 10'h200, 3, 0, 0, 1'b1, '0, 1'b0, 1'b0, 1'b0);

    // Random blocks
    for (int b = 0; b < 25; b++) begin
      run_block(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 10'($urandom),
                int'($urandom_range(0, 8)), 30, 0, 1'b1, '0, 1'b0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
